// File: rtl/cwru_transceiver_tx_encoder.sv
// cwru_transceiver_tx_encoder
// Turns a push-button press on KEY[3:0] into a fixed 8-bit on/off-keyed frame
// on TX (MSB first, BIT_CYCLES clocks per bit), followed by a forced idle-low
// gap of GAP_BITS bit periods before another press is accepted.
module cwru_transceiver_tx_encoder #(
    parameter int BIT_CYCLES = 12500,
    parameter int GAP_BITS   = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] KEY,
    output logic       TX,
    output logic       BUSY,
    output logic       SENT
);

    localparam int GAP_CYCLES = GAP_BITS * BIT_CYCLES;
    localparam int CW         = $clog2(BIT_CYCLES);
    localparam int GW         = $clog2(GAP_CYCLES);

    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CYC_PRE  = CW'(BIT_CYCLES - 2);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state_reg;
    logic [3:0]      sync1_reg;
    logic [3:0]      sync2_reg;
    logic [3:0]      edge_reg;
    logic [3:0]      arm_reg;
    logic [1:0]      settle_reg;
    logic [7:0]      shift_reg;
    logic [CW-1:0]   cyc_cnt_reg;
    logic [2:0]      bit_cnt_reg;
    logic [GW-1:0]   gap_cnt_reg;
    logic            busy_reg;
    logic            sent_reg;

    logic [3:0]      press;
    logic            press_any;
    logic [7:0]      frame_sel;

    // A key only counts as pressed once it has been seen released after reset,
    // so a key held through reset release produces nothing.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_press
            assign press[gi] = arm_reg[gi] & edge_reg[gi] & ~sync2_reg[gi];
        end
    endgenerate

    assign press_any = |press;

    // Lowest-index key wins when several are detected in the same cycle.
    always_comb begin
        frame_sel = 8'h00;
        if (press[0])      frame_sel = 8'b1000_0000;
        else if (press[1]) frame_sel = 8'b1010_0000;
        else if (press[2]) frame_sel = 8'b1010_1000;
        else if (press[3]) frame_sel = 8'b1010_1010;
    end

    // Two-flop synchronizer, edge flop, and per-key arming. Arming waits two
    // clocks after reset so sync2 holds a real sample rather than its reset 1.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_reg  <= 4'hF;
            sync2_reg  <= 4'hF;
            edge_reg   <= 4'hF;
            arm_reg    <= 4'h0;
            settle_reg <= 2'd0;
        end else begin
            sync1_reg <= KEY;
            sync2_reg <= sync1_reg;
            edge_reg  <= sync2_reg;
            if (settle_reg != 2'd2) begin
                settle_reg <= settle_reg + 2'd1;
            end else begin
                arm_reg <= arm_reg | sync2_reg;
            end
        end
    end

    // Frame FSM: the shift register MSB is the line itself; it is all-zero
    // outside SEND, so TX is a pure register output with no gating.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg   <= IDLE;
            shift_reg   <= 8'h00;
            cyc_cnt_reg <= '0;
            bit_cnt_reg <= 3'd0;
            gap_cnt_reg <= '0;
            busy_reg    <= 1'b0;
            sent_reg    <= 1'b0;
        end else begin
            sent_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    busy_reg <= 1'b0;
                    if (press_any) begin
                        shift_reg   <= frame_sel;
                        cyc_cnt_reg <= '0;
                        bit_cnt_reg <= 3'd0;
                        busy_reg    <= 1'b1;
                        state_reg   <= SEND;
                    end
                end
                SEND: begin
                    // Registered one cycle early so SENT lands on the last cycle.
                    if (bit_cnt_reg == 3'd7 && cyc_cnt_reg == CYC_PRE) begin
                        sent_reg <= 1'b1;
                    end
                    if (cyc_cnt_reg == CYC_LAST) begin
                        cyc_cnt_reg <= '0;
                        shift_reg   <= {shift_reg[6:0], 1'b0};
                        if (bit_cnt_reg == 3'd7) begin
                            bit_cnt_reg <= 3'd0;
                            gap_cnt_reg <= '0;
                            state_reg   <= GAP;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        end
                    end else begin
                        cyc_cnt_reg <= cyc_cnt_reg + CW'(1);
                    end
                end
                GAP: begin
                    // Presses seen on the terminal cycle are dropped: still busy.
                    if (gap_cnt_reg == GAP_LAST) begin
                        gap_cnt_reg <= '0;
                        busy_reg    <= 1'b0;
                        state_reg   <= IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign TX   = shift_reg[7];
    assign BUSY = busy_reg;
    assign SENT = sent_reg;

endmodule

// File: tb/tb_cwru_transceiver_tx_encoder.sv
// Testbench for cwru_transceiver_tx_encoder (BIT_CYCLES=10, GAP_BITS=2).
// Stimulus pushes expected frames into a queue; a monitor decodes every frame
// the DUT sends and compares it against the queue head.
module tb_cwru_transceiver_tx_encoder;

    logic       clk;
    logic       rst;
    logic [3:0] key;
    logic       tx;
    logic       busy;
    logic       sent;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    cwru_transceiver_tx_encoder #(
        .BIT_CYCLES(10),
        .GAP_BITS  (2)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .KEY (key),
        .TX  (tx),
        .BUSY(busy),
        .SENT(sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b0 && n < 400);
        chk("wait_idle_timeout", busy, 0);
    endtask

    task automatic send_key(input int idx, input logic [7:0] exp_frame);
        logic [3:0] k;
        @(posedge clk); #1;
        exp_q.push_back(exp_frame);
        k = 4'hF;
        k[idx] = 1'b0;
        key = k;
        repeat (20) @(posedge clk);
        #1 key = 4'hF;
        wait_idle();
        repeat (5) @(posedge clk);
    endtask

    // Monitor: frame starts on the first negedge with BUSY high (cycle k=0).
    initial begin : monitor
        logic [7:0] exp_f;
        logic [7:0] got;
        int         tx_bad;
        int         sent_cnt;
        int         sent_pos;
        bit         aborted;
        bit         have_exp;
        forever begin
            @(negedge clk);
            if (!rst && busy === 1'b1) begin
                have_exp = (exp_q.size() != 0);
                exp_f    = 8'h00;
                if (have_exp) exp_f = exp_q.pop_front();
                got      = 8'h00;
                tx_bad   = 0;
                sent_cnt = 0;
                sent_pos = -1;
                aborted  = 0;
                for (int k = 0; k < 100; k++) begin
                    if (k != 0) @(negedge clk);
                    if (rst || busy !== 1'b1) begin
                        aborted = 1;
                        break;
                    end
                    if (k < 80) begin
                        if (tx !== exp_f[7 - k / 10]) tx_bad++;
                        if (k % 10 == 5) got = {got[6:0], tx};
                    end else if (tx !== 1'b0) begin
                        tx_bad++;
                    end
                    if (sent === 1'b1) begin
                        sent_cnt++;
                        sent_pos = k;
                    end
                end
                if (aborted) begin
                    $display("frame exp=%b aborted rst=%0b", exp_f, rst);
                    if (!rst) chk("busy_dropped_early", 0, 1);
                end else begin
                    @(negedge clk);
                    $display("frame exp=%b got=%b sent_at=%0d", exp_f, got, sent_pos);
                    if (!have_exp) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame actual=%b required=none", got);
                    end
                    chk("frame_bits", got, exp_f);
                    chk("tx_waveform_errors", tx_bad, 0);
                    chk("sent_pulse_count", sent_cnt, 1);
                    chk("sent_cycle", sent_pos, 79);
                    chk("busy_fall", busy, 0);
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int bad;
        rst = 1'b1;
        key = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", tx, 0);
        chk("reset_busy", busy, 0);
        chk("reset_sent", sent, 0);
        rst = 1'b0;

        // Idle with keys released: nothing happens.
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b0 || busy !== 1'b0 || sent !== 1'b0) bad++;
        end
        chk("idle_200_cycles", bad, 0);

        // KEY[0] latency, plus a KEY[1] press landing on the GAP terminal cycle.
        @(posedge clk); #1;                    // edge E0
        exp_q.push_back(8'b1000_0000);
        key = 4'b1110;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);                        // after E0+2
        chk("latency_tx_early", tx, 0);
        chk("latency_busy_early", busy, 0);
        @(posedge clk);
        @(negedge clk);                        // after E0+3
        chk("latency_tx", tx, 1);
        chk("latency_busy", busy, 1);
        key = 4'hF;
        repeat (97) @(posedge clk);            // E0+100
        #1 key = 4'b1101;
        wait_idle();
        repeat (40) @(posedge clk);
        #1 key = 4'hF;
        repeat (10) @(posedge clk);

        // Remaining single-key frames.
        send_key(1, 8'b1010_0000);
        send_key(2, 8'b1010_1000);
        send_key(3, 8'b1010_1010);

        // KEY[3] and KEY[1] together: KEY[1] wins.
        @(posedge clk); #1;
        exp_q.push_back(8'b1010_0000);
        key = 4'b0101;
        repeat (20) @(posedge clk);
        #1 key = 4'hF;
        wait_idle();
        repeat (10) @(posedge clk);

        // KEY[2] pressed during SEND and during GAP of a KEY[0] frame.
        @(posedge clk); #1;                    // E0
        exp_q.push_back(8'b1000_0000);
        key = 4'b1110;
        repeat (30) @(posedge clk);
        #1 key = 4'b1010;                      // SEND
        repeat (10) @(posedge clk);
        #1 key = 4'b1111;
        repeat (50) @(posedge clk);            // ~E0+90, inside GAP
        #1 key = 4'b1011;
        repeat (5) @(posedge clk);
        #1 key = 4'hF;
        wait_idle();
        repeat (150) @(posedge clk);

        // Earliest accepted press: KEY[1] dropped at E0+101 of a KEY[0] frame.
        @(posedge clk); #1;                    // E0
        exp_q.push_back(8'b1000_0000);
        key = 4'b1110;
        repeat (20) @(posedge clk);
        #1 key = 4'hF;
        repeat (81) @(posedge clk);            // E0+101
        #1;
        exp_q.push_back(8'b1010_0000);
        key = 4'b1101;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);                        // after E0+103
        chk("boundary_busy_low", busy, 0);
        @(posedge clk);
        @(negedge clk);                        // after E0+104
        chk("boundary_busy_high", busy, 1);
        chk("boundary_tx_high", tx, 1);
        key = 4'hF;
        wait_idle();
        repeat (10) @(posedge clk);

        // Reset mid-frame during bit 3 of a KEY[3] frame, key held through it.
        @(posedge clk); #1;                    // E0
        exp_q.push_back(8'b1010_1010);
        key = 4'b0111;
        repeat (36) @(posedge clk);            // E0+36, bit 3
        #1;
        chk("pre_reset_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_busy", busy, 0);
        chk("async_reset_tx", tx, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b0) bad++;
        end
        chk("held_key_no_press", bad, 0);
        key = 4'hF;
        repeat (10) @(posedge clk);
        send_key(3, 8'b1010_1010);

        repeat (150) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
